// File: rtl/imem_load_ctrl.sv
// Instruction-memory sequencer: streams a program into the 19-bit instruction memory, then runs the CPU to the halt word.
// Latency: load words pass through to the memory write port in the cycle they are accepted; state changes take effect next cycle.
// Backpressure: ld_ready is high only in LOAD; outside LOAD the loader is held off and no word is taken.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   load_req, start           command pulses (load honoured in IDLE/LOADED/HALTED, start in LOADED/HALTED)
//   ld_valid/ld_ready/ld_data/ld_last   loader word stream
//   halt                      current fetched instruction is the all-zero halt word
//   mem_we/mem_waddr/mem_wdata          instruction memory write port
//   pc_clr, cpu_run           PC clear pulse and PC/register-file update enable
//   busy, overflow, word_cnt, run_cycles   status
module imem_load_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 19,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              start,
  input  logic              halt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              pc_clr,
  output logic              cpu_run,
  output logic              busy,
  output logic              overflow,
  output logic [ADDR_W:0]   word_cnt,
  output logic [CNT_W-1:0]  run_cycles
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    LOADED = 3'd2,
    CLEAR  = 3'd3,
    RUN    = 3'd4,
    HALTED = 3'd5
  } stateT;

  localparam logic [ADDR_W-1:0] addrOne = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   cntOne  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  runOne  = {{(CNT_W-1){1'b0}}, 1'b1};

  stateT             state;
  stateT             nextState;
  logic [ADDR_W-1:0] wrAddr;
  logic [ADDR_W:0]   wordCount;
  logic              ovfFlag;
  logic [CNT_W-1:0]  runCount;

  logic addrAtTop;
  logic enterLoad;
  logic enterClear;

  // The write address stops at the last location instead of wrapping, so a
  // word accepted there always ends the load.
  assign addrAtTop  = &wrAddr;
  assign enterLoad  = (nextState == LOAD)  && (state != LOAD);
  assign enterClear = (nextState == CLEAR) && (state != CLEAR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    ld_ready  = 1'b0;
    mem_we    = 1'b0;
    pc_clr    = 1'b0;
    cpu_run   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (load_req) nextState = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        mem_we   = ld_valid;
        if (ld_valid && (ld_last || addrAtTop)) nextState = LOADED;
      end
      LOADED, HALTED: begin
        // A reload request takes priority over a run request.
        if (load_req)   nextState = LOAD;
        else if (start) nextState = CLEAR;
      end
      CLEAR: begin
        pc_clr    = 1'b1;
        busy      = 1'b1;
        nextState = RUN;
      end
      RUN: begin
        busy = 1'b1;
        // Gate the update enable in the halt cycle so the PC stays on the halt word.
        cpu_run = ~halt;
        if (halt) nextState = HALTED;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Write datapath: the accepted word goes straight to the memory port.
  assign mem_waddr = wrAddr;
  assign mem_wdata = mem_we ? ld_data : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrAddr    <= '0;
      wordCount <= '0;
      ovfFlag   <= 1'b0;
    end else if (enterLoad) begin
      wrAddr    <= '0;
      wordCount <= '0;
      ovfFlag   <= 1'b0;
    end else if (mem_we) begin
      wordCount <= wordCount + cntOne;
      if (!addrAtTop) begin
        wrAddr <= wrAddr + addrOne;
      end else if (!ld_last) begin
        ovfFlag <= 1'b1;
      end
    end
  end

  // Run-cycle counter: zeroed on the way into CLEAR, counts non-halt RUN
  // cycles, sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      runCount <= '0;
    end else if (enterClear) begin
      runCount <= '0;
    end else if ((state == RUN) && !halt && !(&runCount)) begin
      runCount <= runCount + runOne;
    end
  end

  assign overflow   = ovfFlag;
  assign word_cnt   = wordCount;
  assign run_cycles = runCount;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: vector table, directed corner sequences, random traffic against a reference model.
// Latency: inputs applied 1ns after each rising edge, outputs sampled 4ns after it.
// Backpressure: the loader only counts a word as taken when ld_ready is high.
module tb_imem_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        loadReq, ldValid, ldLast, startIn, haltIn;
  logic        ldReady, memWe, pcClr, cpuRun, busy, overflow;
  logic [18:0] ldData, memWdata;
  logic [11:0] memWaddr;
  logic [12:0] wordCnt;
  logic [15:0] runCycles;

  always #5 clk = ~clk;

  imem_load_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (loadReq),
    .ld_valid   (ldValid),
    .ld_ready   (ldReady),
    .ld_data    (ldData),
    .ld_last    (ldLast),
    .start      (startIn),
    .halt       (haltIn),
    .mem_we     (memWe),
    .mem_waddr  (memWaddr),
    .mem_wdata  (memWdata),
    .pc_clr     (pcClr),
    .cpu_run    (cpuRun),
    .busy       (busy),
    .overflow   (overflow),
    .word_cnt   (wordCnt),
    .run_cycles (runCycles)
  );

  int nChecks = 0;
  int nFail   = 0;
  int weCount, clrCount, runCount, lastWaddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the controller's observable phase plus plain counters.
  typedef enum {P_IDLE, P_LOAD, P_LOADED, P_CLEAR, P_RUN, P_HALTED} phaseE;
  phaseE mPh;
  int    mCnt, mRun;
  bit    mOvf;

  task automatic modelReset();
    mPh = P_IDLE; mCnt = 0; mRun = 0; mOvf = 0;
  endtask

  typedef struct {
    bit lr, st, v, last, h;
    logic [18:0] d;
    bit eRdy, eWe, eClr, eRun, eBusy;
    int eAddr, eCnt, eRc;
  } vecT;
  vecT vecs[14];

  // One clock cycle: apply inputs, check outputs against the model (and a
  // table row if given), then advance the model past the rising edge.
  task automatic drive(input bit lr, input bit st, input bit v, input bit last,
                       input bit h, input logic [18:0] d, input int tbl);
    bit eRdy, eWe, eClr, eRun, eBusy;
    loadReq = lr; startIn = st; ldValid = v; ldLast = last; haltIn = h; ldData = d;
    #3;
    eRdy  = (mPh == P_LOAD);
    eWe   = eRdy && v;
    eClr  = (mPh == P_CLEAR);
    eRun  = (mPh == P_RUN) && !h;
    eBusy = (mPh == P_LOAD) || (mPh == P_CLEAR) || (mPh == P_RUN);
    chk("ld_ready", ldReady, eRdy);
    chk("mem_we", memWe, eWe);
    chk("pc_clr", pcClr, eClr);
    chk("cpu_run", cpuRun, eRun);
    chk("busy", busy, eBusy);
    chk("overflow", overflow, mOvf);
    chk("word_cnt", wordCnt, mCnt);
    chk("run_cycles", runCycles, mRun);
    if (eWe) begin
      chk("mem_waddr", memWaddr, mCnt);
      chk("mem_wdata", memWdata, d);
    end
    if (tbl >= 0) begin
      chk("tbl_ld_ready", ldReady, vecs[tbl].eRdy);
      chk("tbl_mem_we", memWe, vecs[tbl].eWe);
      chk("tbl_pc_clr", pcClr, vecs[tbl].eClr);
      chk("tbl_cpu_run", cpuRun, vecs[tbl].eRun);
      chk("tbl_busy", busy, vecs[tbl].eBusy);
      chk("tbl_word_cnt", wordCnt, vecs[tbl].eCnt);
      chk("tbl_run_cycles", runCycles, vecs[tbl].eRc);
      if (vecs[tbl].eWe) begin
        chk("tbl_mem_waddr", memWaddr, vecs[tbl].eAddr);
        chk("tbl_mem_wdata", memWdata, vecs[tbl].d);
      end
    end
    if (memWe) begin weCount++; lastWaddr = memWaddr; end
    if (pcClr) clrCount++;
    if (cpuRun) runCount++;
    @(posedge clk); #1;
    case (mPh)
      P_IDLE: if (lr) begin mPh = P_LOAD; mCnt = 0; mOvf = 0; end
      P_LOAD: if (v) begin
        mCnt++;
        if (last) mPh = P_LOADED;
        else if (mCnt == 4096) begin mPh = P_LOADED; mOvf = 1; end
      end
      P_LOADED, P_HALTED: begin
        if (lr) begin mPh = P_LOAD; mCnt = 0; mOvf = 0; end
        else if (st) begin mPh = P_CLEAR; mRun = 0; end
      end
      P_CLEAR: mPh = P_RUN;
      P_RUN: begin
        if (h) mPh = P_HALTED;
        else if (mRun < 65535) mRun++;
      end
      default: mPh = P_IDLE;
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, '0, -1);
  endtask

  // Called 1ns after a rising edge (or at start); checks the reset values.
  task automatic doReset();
    loadReq = 0; startIn = 0; ldValid = 0; ldLast = 0; haltIn = 0; ldData = '0;
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cpu_run", cpuRun, 0);
    chk("rst_ld_ready", ldReady, 0);
    chk("rst_mem_we", memWe, 0);
    chk("rst_pc_clr", pcClr, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_word_cnt", wordCnt, 0);
    chk("rst_run_cycles", runCycles, 0);
    chk("rst_mem_waddr", memWaddr, 0);
    chk("rst_mem_wdata", memWdata, 0);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    modelReset();
  endtask

  initial begin
    //          lr st v  ls h  data       rdy we clr run bsy addr cnt rc
    vecs[0]  = '{0, 1, 0, 0, 0, 19'h0,     0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 19'h0,     0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 1, 0, 0, 19'h12345, 1, 1, 0, 0, 1, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 19'h0,     1, 0, 0, 0, 1, 0, 1, 0};
    vecs[4]  = '{0, 0, 1, 1, 0, 19'h00007, 1, 1, 0, 0, 1, 1, 1, 0};
    vecs[5]  = '{0, 1, 0, 0, 0, 19'h0,     0, 0, 0, 0, 0, 0, 2, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 19'h0,     0, 0, 1, 0, 1, 0, 2, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 19'h0,     0, 0, 0, 1, 1, 0, 2, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 19'h0,     0, 0, 0, 1, 1, 0, 2, 1};
    vecs[9]  = '{0, 0, 0, 0, 1, 19'h0,     0, 0, 0, 0, 1, 0, 2, 2};
    vecs[10] = '{1, 1, 0, 0, 0, 19'h0,     0, 0, 0, 0, 0, 0, 2, 2};
    vecs[11] = '{0, 0, 1, 1, 0, 19'h00005, 1, 1, 0, 0, 1, 0, 0, 2};
    vecs[12] = '{1, 1, 0, 0, 0, 19'h0,     0, 0, 0, 0, 0, 0, 1, 2};
    vecs[13] = '{0, 0, 0, 0, 0, 19'h0,     1, 0, 0, 0, 1, 0, 0, 2};

    rst = 1'b1;
    loadReq = 0; startIn = 0; ldValid = 0; ldLast = 0; haltIn = 0; ldData = '0;
    #1;
    doReset();

    // Vector table.
    for (int i = 0; i < 14; i++)
      drive(vecs[i].lr, vecs[i].st, vecs[i].v, vecs[i].last, vecs[i].h, vecs[i].d, i);

    // Ten-word load with no stalls.
    doReset();
    drive(1, 0, 0, 0, 0, '0, -1);
    weCount = 0;
    for (int i = 0; i < 10; i++) drive(0, 0, 1, i == 9, 0, 19'($urandom), -1);
    chk("load10_writes", weCount, 10);
    chk("load10_last_addr", lastWaddr, 9);
    chk("load10_word_cnt", wordCnt, 10);
    chk("load10_loaded_busy", busy, 0);

    // Loader stall mid-stream.
    doReset();
    drive(1, 0, 0, 0, 0, '0, -1);
    weCount = 0;
    drive(0, 0, 1, 0, 0, 19'h1, -1);
    drive(0, 0, 1, 0, 0, 19'h2, -1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 19'h7FFFF, -1);
    drive(0, 0, 1, 0, 0, 19'h3, -1);
    drive(0, 0, 1, 1, 0, 19'h4, -1);
    chk("stall_writes", weCount, 4);
    chk("stall_last_addr", lastWaddr, 3);
    chk("stall_word_cnt", wordCnt, 4);

    // Run with halt on the 7th RUN cycle.
    clrCount = 0; runCount = 0;
    drive(0, 1, 0, 0, 0, '0, -1);
    drive(0, 0, 0, 0, 0, '0, -1);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, '0, -1);
    drive(0, 0, 0, 0, 1, '0, -1);
    chk("run_pc_clr_pulses", clrCount, 1);
    chk("run_cpu_run_cycles", runCount, 6);
    chk("run_cycles_count", runCycles, 6);
    chk("run_halted_busy", busy, 0);

    // Re-run from HALTED without reload: counter restarts.
    drive(0, 1, 0, 0, 0, '0, -1);
    drive(0, 0, 0, 0, 0, '0, -1);
    chk("rerun_cycles_zero", runCycles, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, '0, -1);
    drive(0, 0, 0, 0, 1, '0, -1);
    chk("rerun_cycles", runCycles, 3);
    chk("rerun_word_cnt_held", wordCnt, 4);

    // HALTED with start and load_req together: load wins, no PC clear.
    clrCount = 0;
    drive(1, 1, 0, 0, 0, '0, -1);
    drive(0, 0, 0, 0, 0, '0, -1);
    chk("both_no_pc_clr", clrCount, 0);
    chk("both_in_load", ldReady, 1);
    drive(0, 0, 1, 1, 0, 19'h4ABCD, -1);
    chk("single_word_cnt", wordCnt, 1);

    // Asynchronous reset in the middle of RUN.
    drive(0, 1, 0, 0, 0, '0, -1);
    drive(0, 0, 0, 0, 0, '0, -1);
    drive(0, 0, 0, 0, 0, '0, -1);
    drive(0, 0, 0, 0, 0, '0, -1);
    loadReq = 0; startIn = 0; ldValid = 0; ldLast = 0; haltIn = 0;
    #1;
    chk("midrun_cpu_run_before", cpuRun, 1);
    rst = 1'b0;
    #1;
    chk("midrun_cpu_run_async", cpuRun, 0);
    chk("midrun_busy", busy, 0);
    chk("midrun_run_cycles", runCycles, 0);
    chk("midrun_word_cnt", wordCnt, 0);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    modelReset();
    drive(0, 1, 0, 0, 0, '0, -1);
    drive(1, 0, 0, 0, 0, '0, -1);
    chk("after_rst_load_accepted", ldReady, 1);

    // Overflow: 4097 words offered with no last marker.
    doReset();
    drive(1, 0, 0, 0, 0, '0, -1);
    weCount = 0;
    for (int i = 0; i < 4097; i++) drive(0, 0, 1, 0, 0, 19'($urandom), -1);
    chk("ovf_writes", weCount, 4096);
    chk("ovf_last_addr", lastWaddr, 4095);
    chk("ovf_flag", overflow, 1);
    chk("ovf_word_cnt", wordCnt, 4096);
    chk("ovf_not_ready", ldReady, 0);

    // Random traffic against the model.
    doReset();
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6,
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 12,
            $urandom_range(0, 99) < 12, 19'($urandom), -1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
